// File: rtl/regfile_read_port_if.sv
// Request/response handshake bundle for the register file read port.
//   req_valid/req_ready   : operand fetch request handshake
//   req_idx_a/req_idx_b   : operand register indices
//   rsp_valid/rsp_ready   : registered response handshake
//   rsp_data_a/rsp_data_b : operand values
//   rd_count              : number of responses consumed (wraps)
// master = requester/consumer (execute stage), slave = read port.
interface regfile_read_port_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [IDX_W-1:0]  req_idx_a;
    logic [IDX_W-1:0]  req_idx_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;
    logic [15:0]       rd_count;

    modport master (
        output req_valid, req_idx_a, req_idx_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, rd_count
    );

    modport slave (
        input  req_valid, req_idx_a, req_idx_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data_a, rsp_data_b, rd_count
    );
endinterface

// File: rtl/regfile_read_port.sv
// Read side of the datapath register file.
// Holds NREGS x DATA_W registers written by two write ports (port 1 wins on
// a same-index collision) and serves two-operand read requests through a
// single registered response stage with valid/ready backpressure.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   write0/num_write0_in/... : write port 0 (enable, index, data)
//   write1/num_write1_in/... : write port 1 (enable, index, data)
//   rp                       : request/response handshake (slave side)
module regfile_read_port #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write0,
    input  logic [IDX_W-1:0]  num_write0_in,
    input  logic [DATA_W-1:0] data_write0_in,
    input  logic              write1,
    input  logic [IDX_W-1:0]  num_write1_in,
    input  logic [DATA_W-1:0] data_write1_in,
    regfile_read_port_if.slave rp
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic              req_ready;
    logic              accept;
    logic              consume;

    // Single output stage: a consume frees the slot on the same edge.
    assign req_ready = (state_q == StEmpty) || rp.rsp_ready;
    assign accept    = rp.req_valid && req_ready;
    assign consume   = (state_q == StFull) && rp.rsp_ready;

    // Next register contents. Port 1 is applied last so it wins a collision;
    // reading regs_d at acceptance therefore gives the write-first bypass.
    always_comb begin
        regs_d = regs_q;
        if (write0) regs_d[num_write0_in] = data_write0_in;
        if (write1) regs_d[num_write1_in] = data_write1_in;
    end

    always_comb begin
        state_d    = state_q;
        rsp_a_d    = rsp_a_q;
        rsp_b_d    = rsp_b_q;
        rd_count_d = rd_count_q;
        if (consume) rd_count_d = rd_count_q + 16'd1;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (consume && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
        // Snapshot at acceptance; held data is never refreshed by later writes.
        if (accept) begin
            rsp_a_d = regs_d[rp.req_idx_a];
            rsp_b_d = regs_d[rp.req_idx_b];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StEmpty;
            rsp_a_q    <= '0;
            rsp_b_q    <= '0;
            rd_count_q <= '0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rsp_a_q    <= rsp_a_d;
            rsp_b_q    <= rsp_b_d;
            rd_count_q <= rd_count_d;
            regs_q     <= regs_d;
        end
    end

    assign rp.req_ready  = req_ready;
    assign rp.rsp_valid  = (state_q == StFull);
    assign rp.rsp_data_a = rsp_a_q;
    assign rp.rsp_data_b = rsp_b_q;
    assign rp.rd_count   = rd_count_q;

endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        write0, write1;
    logic [2:0]  num_write0_in, num_write1_in;
    logic [15:0] data_write0_in, data_write1_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model [8];

    regfile_read_port_if #(.DATA_W(16), .IDX_W(3)) rp ();

    regfile_read_port #(.DATA_W(16), .NREGS(8), .IDX_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .write0         (write0),
        .num_write0_in  (num_write0_in),
        .data_write0_in (data_write0_in),
        .write1         (write1),
        .num_write1_in  (num_write1_in),
        .data_write1_in (data_write1_in),
        .rp             (rp.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [2:0] a, input logic [2:0] b);
        rp.req_valid = 1'b1;
        rp.req_idx_a = a;
        rp.req_idx_b = b;
    endtask

    initial begin
        rst = 1'b0;
        write0 = 1'b0; write1 = 1'b0;
        num_write0_in = '0; num_write1_in = '0;
        data_write0_in = '0; data_write1_in = '0;
        rp.req_valid = 1'b0; rp.req_idx_a = '0; rp.req_idx_b = '0;
        rp.rsp_ready = 1'b0;

        // 1: reset, then read zeros
        @(negedge clk);
        step();
        step();
        check_eq("rst_valid", rp.rsp_valid, 0);
        check_eq("rst_count", rp.rd_count, 0);
        check_eq("rst_data_a", rp.rsp_data_a, 0);
        rst = 1'b1;
        req(3, 7);
        step();
        rp.req_valid = 1'b0;
        check_eq("t1_valid", rp.rsp_valid, 1);
        check_eq("t1_a", rp.rsp_data_a, 16'h0000);
        check_eq("t1_b", rp.rsp_data_b, 16'h0000);
        rp.rsp_ready = 1'b1;
        step();
        check_eq("t1_consumed", rp.rsp_valid, 0);
        check_eq("t1_count", rp.rd_count, 1);

        // 2: write then read same index on both operands
        write0 = 1'b1; num_write0_in = 3'd2; data_write0_in = 16'h1234;
        step();
        write0 = 1'b0;
        req(2, 2);
        step();
        rp.req_valid = 1'b0;
        check_eq("t2_valid", rp.rsp_valid, 1);
        check_eq("t2_a", rp.rsp_data_a, 16'h1234);
        check_eq("t2_b", rp.rsp_data_b, 16'h1234);
        step();
        check_eq("t2_count", rp.rd_count, 2);

        // 3: bypass on the accepting edge, port 1 wins over port 0
        write1 = 1'b1; num_write1_in = 3'd6; data_write1_in = 16'h0066;
        step();
        write1 = 1'b0;
        req(5, 6);
        write0 = 1'b1; num_write0_in = 3'd5; data_write0_in = 16'hAAAA;
        write1 = 1'b1; num_write1_in = 3'd5; data_write1_in = 16'hBBBB;
        step();
        write0 = 1'b0; write1 = 1'b0;
        rp.req_valid = 1'b0;
        check_eq("t3_byp_a", rp.rsp_data_a, 16'hBBBB);
        check_eq("t3_old_b", rp.rsp_data_b, 16'h0066);
        step();
        req(5, 5);
        step();
        rp.req_valid = 1'b0;
        check_eq("t3_r5", rp.rsp_data_a, 16'hBBBB);
        step();
        req(4, 5);
        write0 = 1'b1; num_write0_in = 3'd4; data_write0_in = 16'h4444;
        step();
        write0 = 1'b0;
        rp.req_valid = 1'b0;
        check_eq("t3_byp0_a", rp.rsp_data_a, 16'h4444);
        check_eq("t3_byp0_b", rp.rsp_data_b, 16'hBBBB);
        step();
        check_eq("t3_count", rp.rd_count, 5);

        // 4: backpressure, snapshot held against later writes
        rp.rsp_ready = 1'b0;
        write0 = 1'b1; num_write0_in = 3'd1; data_write0_in = 16'h0001;
        step();
        write0 = 1'b0;
        req(1, 1);
        step();
        rp.req_valid = 1'b0;
        check_eq("t4_a", rp.rsp_data_a, 16'h0001);
        check_eq("t4_ready_lo", rp.req_ready, 0);
        write0 = 1'b1; num_write0_in = 3'd1; data_write0_in = 16'hFFFF;
        step();
        write0 = 1'b0;
        check_eq("t4_hold_a", rp.rsp_data_a, 16'h0001);
        check_eq("t4_hold_valid", rp.rsp_valid, 1);
        req(2, 2);
        step();
        check_eq("t4_no_accept_a", rp.rsp_data_a, 16'h0001);
        check_eq("t4_no_accept_b", rp.rsp_data_b, 16'h0001);
        check_eq("t4_count_held", rp.rd_count, 5);
        rp.req_valid = 1'b0;
        rp.rsp_ready = 1'b1;
        #1;
        check_eq("t4_ready_hi", rp.req_ready, 1);
        step();
        check_eq("t4_count", rp.rd_count, 6);
        check_eq("t4_empty", rp.rsp_valid, 0);
        check_eq("t4_data_kept", rp.rsp_data_a, 16'h0001);
        req(1, 0);
        step();
        rp.req_valid = 1'b0;
        check_eq("t4_r1_new", rp.rsp_data_a, 16'hFFFF);
        step();

        // 5: streaming, one response per cycle
        model[0] = 16'h0000; model[1] = 16'hFFFF; model[2] = 16'h1234; model[3] = 16'h0000;
        model[4] = 16'h4444; model[5] = 16'hBBBB; model[6] = 16'h0066; model[7] = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            req(3'(i % 8), 3'((i + 1) % 8));
            #1;
            check_eq($sformatf("t5_ready%0d", i), rp.req_ready, 1);
            step();
            check_eq($sformatf("t5_valid%0d", i), rp.rsp_valid, 1);
            check_eq($sformatf("t5_a%0d", i), rp.rsp_data_a, model[i % 8]);
            check_eq($sformatf("t5_b%0d", i), rp.rsp_data_b, model[(i + 1) % 8]);
        end
        rp.req_valid = 1'b0;
        step();
        check_eq("t5_count", rp.rd_count, 17);

        // 6: reset with a response pending and a request presented
        rp.rsp_ready = 1'b0;
        req(2, 4);
        step();
        check_eq("t6_pending", rp.rsp_valid, 1);
        rst = 1'b0;
        rp.rsp_ready = 1'b1;
        req(2, 4);
        step();
        rst = 1'b1;
        rp.req_valid = 1'b0;
        check_eq("t6_valid", rp.rsp_valid, 0);
        check_eq("t6_count", rp.rd_count, 0);
        check_eq("t6_data", rp.rsp_data_a, 0);
        req(2, 2);
        step();
        rp.req_valid = 1'b0;
        check_eq("t6_regs_clr", rp.rsp_data_a, 16'h0000);
        step();
        check_eq("t6_count1", rp.rd_count, 1);

        // Stream up to 0xFFFF consumed, then one more wraps to zero
        req(0, 0);
        repeat (65534) step();
        rp.req_valid = 1'b0;
        step();
        check_eq("t6_count_max", rp.rd_count, 16'hFFFF);
        req(0, 0);
        step();
        rp.req_valid = 1'b0;
        step();
        check_eq("t6_wrap", rp.rd_count, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
